// File: rtl/tetromino_cell_engine_pkg.sv
// tetris_pkg: shared definitions for the playfield engine and the video path.
//   - piece and operation codes, engine FSM state encoding
//   - BLACK/WHITE colour words and the per-piece colour table (piece_color)
//   - HIDDEN_ROWS / CELL_PX geometry constants used by the video renderer
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I    = 3'd0,
    PIECE_O    = 3'd1,
    PIECE_L    = 3'd2,
    PIECE_J    = 3'd3,
    PIECE_S    = 3'd4,
    PIECE_Z    = 3'd5,
    PIECE_T    = 3'd6,
    PIECE_NONE = 3'd7
  } piece_e;

  typedef enum logic [1:0] {
    OP_DRAW  = 2'd0,
    OP_ERASE = 2'd1,
    OP_CHECK = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_SAMPLE,
    ST_FIN
  } state_e;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFF0;

  localparam int unsigned HIDDEN_ROWS = 2;
  localparam int unsigned CELL_PX     = 10;

  // Colour word is {r[3:0], g[3:0], b[3:0], 4'b0}.
  function automatic logic [15:0] piece_color(input logic [2:0] piece);
    logic [15:0] c;
    case (piece)
      PIECE_I: c = 16'h0FF0;
      PIECE_O: c = 16'hFF00;
      PIECE_L: c = 16'hFA00;
      PIECE_J: c = 16'h00F0;
      PIECE_S: c = 16'h0F00;
      PIECE_Z: c = 16'hF000;
      PIECE_T: c = 16'hF0F0;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tetromino_cell_engine_if.sv
// Memory bus between the cell engine and the SRAM arbiter.
//   master (engine): drives mem_req, mem_we, mem_addr, mem_wdata; receives mem_grant, mem_rdata
//   slave (arbiter): the reverse
// An access is performed in a cycle where mem_req && mem_grant; read data
// is valid the cycle after the granted read.
interface tetromino_cell_engine_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              mem_req;
  logic              mem_grant;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_grant, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_grant, mem_rdata
  );
endinterface

// File: rtl/tetromino_cell_engine_shape_rom.sv
// tetromino_shape_rom: combinational cell-offset table.
//   piece[2:0], rot[1:0] in -> cells[0:3] out, each {dx[1:0], dy[1:0]} inside
//   the 4x4 bounding box, listed row-major (top-left first).
//   Piece code 7 returns all-zero offsets; the engine rejects it separately.
module tetromino_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0]       piece,
  input  logic [1:0]       rot,
  output logic [0:3][3:0]  cells
);

  // One hex digit per cell: digit = dx*4 + dy, cell 0 in the leftmost digit.
  localparam logic [15:0] SHAPES [8][4] = '{
    '{16'h0123, 16'h159D, 16'h4567, 16'h26AE},   // I
    '{16'h0415, 16'h0415, 16'h0415, 16'h0415},   // O
    '{16'h8159, 16'h456A, 16'h1592, 16'h0456},   // L
    '{16'h0159, 16'h4856, 16'h159A, 16'h4526},   // J
    '{16'h4815, 16'h459A, 16'h5926, 16'h0156},   // S
    '{16'h0459, 16'h8596, 16'h156A, 16'h4152},   // Z
    '{16'h4159, 16'h4596, 16'h1596, 16'h4156},   // T
    '{16'h0000, 16'h0000, 16'h0000, 16'h0000}    // invalid
  };

  always_comb begin
    cells = SHAPES[piece][rot];
  end

endmodule

// File: rtl/tetromino_cell_engine.sv
// tetromino_cell_engine: performs one piece operation on the playfield memory
// per accepted request.
//   VGA_CTRL_CLK, RST (async, active-low)
//   req_valid/req_ready         request handshake; req_op, req_piece, req_rot,
//                               req_x, req_y latched on accept
//   done                        one-cycle pulse at the end of each request
//   collide                     result, valid with done, held until next accept
//   mem (master modport)        time-shared SRAM port, addr = {x, y, 8'b0}
// DRAW writes the piece colour to its 4 cells, ERASE writes BLACK, CHECK reads
// the cells and reports collide on the first occupied one. Out-of-field cells,
// piece 7 and op 3 report collide without touching memory.
module tetromino_cell_engine
  import tetris_pkg::*;
#(
  parameter int unsigned FIELD_W = 10,
  parameter int unsigned FIELD_H = 22,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned ADDR_W  = 18
) (
  input  logic               VGA_CTRL_CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [2:0]         req_piece,
  input  logic [1:0]         req_rot,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               done,
  output logic               collide,
  tetromino_cell_engine_if.master mem
);

  localparam logic [COORD_W:0] FIELD_W_C = (COORD_W+1)'(FIELD_W);
  localparam logic [COORD_W:0] FIELD_H_C = (COORD_W+1)'(FIELD_H);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [2:0]         piece_q, piece_d;
  logic [1:0]         rot_q, rot_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]         idx_q, idx_d;
  logic [COORD_W-1:0] cell_x_q [4];
  logic [COORD_W-1:0] cell_x_d [4];
  logic [COORD_W-1:0] cell_y_q [4];
  logic [COORD_W-1:0] cell_y_d [4];
  logic               req_ready_q, req_ready_d;
  logic               done_q, done_d;
  logic               collide_q, collide_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;

  logic [0:3][3:0]    offs;
  logic [COORD_W:0]   calc_x [4];
  logic [COORD_W:0]   calc_y [4];
  logic               oob;
  logic               occupied;
  logic [1:0]         idx_inc;

  tetromino_shape_rom u_shape_rom (
    .piece (piece_q),
    .rot   (rot_q),
    .cells (offs)
  );

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] cx,
                                                  input logic [COORD_W-1:0] cy);
    return {cx, cy, 8'h00};
  endfunction

  // One extra bit on the sum so an origin near the top of the coordinate
  // range cannot wrap back into the field.
  always_comb begin
    oob = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      calc_x[i] = {1'b0, x_q} + {{(COORD_W-1){1'b0}}, offs[i][3:2]};
      calc_y[i] = {1'b0, y_q} + {{(COORD_W-1){1'b0}}, offs[i][1:0]};
      if (calc_x[i] >= FIELD_W_C || calc_y[i] >= FIELD_H_C) begin
        oob = 1'b1;
      end
    end
  end

  // Colour nibbles only; the low 4 bits of a cell word carry no occupancy.
  assign occupied = |(mem.mem_rdata & 16'hFFF0);
  assign idx_inc  = idx_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    piece_d     = piece_q;
    rot_d       = rot_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    cell_x_d    = cell_x_q;
    cell_y_d    = cell_y_q;
    req_ready_d = req_ready_q;
    done_d      = 1'b0;
    collide_d   = collide_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          op_d        = op_e'(req_op);
          piece_d     = req_piece;
          rot_d       = req_rot;
          x_d         = req_x;
          y_d         = req_y;
          collide_d   = 1'b0;
          req_ready_d = 1'b0;
          state_d     = ST_CALC;
        end
      end

      ST_CALC: begin
        idx_d = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
          cell_x_d[i] = calc_x[i][COORD_W-1:0];
          cell_y_d[i] = calc_y[i][COORD_W-1:0];
        end
        if (oob || piece_q == PIECE_NONE || op_q == OP_RSVD) begin
          collide_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_FIN;
        end else begin
          mem_req_d   = 1'b1;
          mem_addr_d  = cell_addr(calc_x[0][COORD_W-1:0], calc_y[0][COORD_W-1:0]);
          mem_we_d    = (op_q != OP_CHECK);
          mem_wdata_d = (op_q == OP_DRAW) ? piece_color(piece_q) : BLACK;
          state_d     = (op_q == OP_CHECK) ? ST_RD_ISSUE : ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (mem_req_q && mem.mem_grant) begin
          if (idx_q == 2'd3) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_FIN;
          end else begin
            idx_d      = idx_inc;
            mem_addr_d = cell_addr(cell_x_q[idx_inc], cell_y_q[idx_inc]);
          end
        end
      end

      ST_RD_ISSUE: begin
        if (mem_req_q && mem.mem_grant) begin
          mem_req_d = 1'b0;
          state_d   = ST_RD_SAMPLE;
        end
      end

      ST_RD_SAMPLE: begin
        if (occupied) begin
          collide_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_FIN;
        end else if (idx_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          idx_d      = idx_inc;
          mem_req_d  = 1'b1;
          mem_addr_d = cell_addr(cell_x_q[idx_inc], cell_y_q[idx_inc]);
          state_d    = ST_RD_ISSUE;
        end
      end

      ST_FIN: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_DRAW;
      piece_q     <= '0;
      rot_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      cell_x_q    <= '{default: '0};
      cell_y_q    <= '{default: '0};
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      collide_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      piece_q     <= piece_d;
      rot_q       <= rot_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      collide_q   <= collide_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign done          = done_q;
  assign collide       = collide_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
